// File: rtl/key_loader.sv
// Assembles a KEY_W key from a WORD_W word stream, presents it with a one-cycle load strobe, then zeroizes.
// Optional feature: define KEY_LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES idle cycles in COLLECT.
`timescale 1ns/1ps
module key_loader #(
  parameter int WORD_W         = 32,
  parameter int KEY_W          = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              clear_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  input  logic [WORD_W-1:0] word_data_i,
  input  logic              word_last_i,
  output logic [KEY_W-1:0]  key_data_o,
  output logic              key_load_o,
  output logic              busy_o,
  output logic              error_o,
  output logic [1:0]        state_o    // debug: 0 IDLE, 1 COLLECT, 2 COMMIT, 3 ERROR
);

  localparam int N_WORDS = KEY_W / WORD_W;
  localparam int CW      = $clog2(N_WORDS + 1);

  if (KEY_W % WORD_W != 0) begin : g_bad_width
    $error("key_loader: KEY_W must be a multiple of WORD_W");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("key_loader: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMMIT  = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               armed_q;
  logic [KEY_W-1:0]   shadow_q, shadow_d, shadow_ins;
  logic [CW-1:0]      count_q, count_d;
  logic               error_q, error_d;
  logic               accept;
  logic               timeout_hit;

  // Handshake: a word transfers on a rising edge where word_valid_i and word_ready_o
  // are both high; ready never depends on valid, and is low only in reset, in the
  // first cycle after reset release, and in the COMMIT cycle.
  assign accept = word_valid_i & word_ready_o;

`ifdef KEY_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      idle_cnt_q <= '0;
    end else if (clear_i || (state_q != S_COLLECT) || accept || timeout_hit) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_q + TW'(1);
    end
  end

  assign timeout_hit = (state_q == S_COLLECT) && !accept &&
                       (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Drop the incoming word into its MSW-first slot.
  always_comb begin
    shadow_ins = shadow_q;
    for (int k = 0; k < N_WORDS; k++) begin
      if (count_q == CW'(k)) begin
        shadow_ins[KEY_W-1-k*WORD_W -: WORD_W] = word_data_i;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_IDLE;
      armed_q  <= 1'b0;
      shadow_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    error_d  = error_q;
    if (clear_i) begin
      state_d  = S_IDLE;
      shadow_d = '0;
      count_d  = '0;
      error_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_COLLECT: begin
          if (accept) begin
            if (count_q == CW'(N_WORDS - 1)) begin
              if (word_last_i) begin
                state_d  = S_COMMIT;
                shadow_d = shadow_ins;
                count_d  = count_q + CW'(1);
              end else begin
                // Frame overran: discard the rest up to the next last flag.
                state_d  = S_ERROR;
                shadow_d = '0;
                count_d  = '0;
                error_d  = 1'b1;
              end
            end else if (word_last_i) begin
              state_d  = S_IDLE;
              shadow_d = '0;
              count_d  = '0;
              error_d  = 1'b1;
            end else begin
              state_d  = S_COLLECT;
              shadow_d = shadow_ins;
              count_d  = count_q + CW'(1);
            end
          end else if (timeout_hit) begin
            state_d  = S_IDLE;
            shadow_d = '0;
            count_d  = '0;
            error_d  = 1'b1;
          end
        end
        S_COMMIT: begin
          state_d  = S_IDLE;
          shadow_d = '0;
          count_d  = '0;
          error_d  = 1'b0;
        end
        S_ERROR: begin
          error_d = 1'b1;
          if (accept && word_last_i) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d  = S_IDLE;
          shadow_d = '0;
          count_d  = '0;
        end
      endcase
    end
  end

  // The key leaves the block only during an unaborted COMMIT cycle.
  always_comb begin
    word_ready_o = armed_q && (state_q != S_COMMIT);
    key_load_o   = (state_q == S_COMMIT) && !clear_i;
    key_data_o   = key_load_o ? shadow_q : '0;
    busy_o       = (state_q != S_IDLE);
    error_o      = error_q;
    state_o      = state_q;
  end

  a_key_hidden: assert property (@(posedge clock_i) disable iff (!reset_n_i)
    !key_load_o |-> (key_data_o == '0));
  a_commit_once: assert property (@(posedge clock_i) disable iff (!reset_n_i)
    (state_q == S_COMMIT) |=> (state_q == S_IDLE));

endmodule
